regs_port_arbiter: RTL and testbench
====================================

# regs_port_arbiter

Shares the SATA controller register memory between the AXI slave path (the `axibram_write`/`axibram_read` pair behind the MAXI GP1 register window) and the internal host/DMA engine. The register memory is simple dual-port: one write port and one read port, read latency 1. AXI accesses are never stalled inside a cycle; the host side is served in AXI idle slots. A starvation counter throttles AXI through the `dev_ready` inputs of the AXI converters.

## Interface
- `ADDR_BITS`, 16: register word-address width.
- `STARVE_LIMIT`, 8: consecutive blocked host-request cycles before AXI throttling. Range 1..255.
- `ACLK` in 1: sole clock.
- `ARESETN` in 1: asynchronous active-low reset.
- `axi_waddr` in ADDR_BITS: AXI write word address.
- `axi_wen` in 1: AXI write enable.
- `axi_wstb` in 4: AXI write byte strobes.
- `axi_wdata` in 32: AXI write data.
- `axi_raddr` in ADDR_BITS: AXI read word address.
- `axi_ren` in 1: AXI read enable.
- `axi_regen` in 1: AXI read-data register enable, one cycle after `axi_ren`.
- `axi_rdata` out 32: read data to the AXI read converter.
- `wr_dev_ready` out 1: drives `dev_ready` of the write converter.
- `rd_dev_ready` out 1: drives `dev_ready` of the read converter.
- `hst_req` in 1: host request. Held until `hst_ack`.
- `hst_we` in 1: 1 = write, 0 = read. Stable while `hst_req` is high.
- `hst_addr` in ADDR_BITS; `hst_wdata` in 32; `hst_wstb` in 4: host access fields. Stable while `hst_req` is high.
- `hst_ack` out 1: one-cycle pulse; the access is issued to memory this cycle.
- `hst_rdata` out 32: registered host read data. Held until the next host read completes.
- `hst_rvalid` out 1: one-cycle pulse when `hst_rdata` is updated.
- `mem_waddr` out ADDR_BITS; `mem_we` out 1; `mem_wstb` out 4; `mem_wdata` out 32: memory write port.
- `mem_raddr` out ADDR_BITS; `mem_re` out 1: memory read port.
- `mem_rdata` in 32: memory read data, valid the cycle after `mem_re`.

## Operation
- Write port mux is combinational.
  - `axi_wen` = 1: the AXI write owns the port.
  - Otherwise, `hst_req & hst_we`: the host write owns the port, and `hst_ack` = 1 in the same cycle.
- Read port mux works the same way, with `axi_ren` against `hst_req & ~hst_we`.
- A host read issued in cycle t sets a registered tag. At t+1, `hst_rdata` <= `mem_rdata`. At t+2, `hst_rvalid` = 1.
- `axi_rdata` = `mem_rdata` passthrough. The AXI converter registers it on `axi_regen`.
- Host and AXI can use opposite ports in the same cycle. Example: AXI write + host read both proceed.
- Same-address write and read in the same cycle is read-first: the read returns the old value.
- Starvation counter (8 bit):
  - Increments each cycle `hst_req` = 1 and `hst_ack` = 0.
  - Clears on `hst_ack`, or when `hst_req` = 0.
  - Saturates at STARVE_LIMIT.
- Throttle: while counter == STARVE_LIMIT, the `dev_ready` of the port the host needs is driven 0.
  - `hst_we` = 1 → `wr_dev_ready` = 0.
  - `hst_we` = 0 → `rd_dev_ready` = 0.
- Throttle is released in the cycle after `hst_ack`.
- Upstream contract: no new enable on a port from the cycle after its `dev_ready` falls. An enable in the same cycle is still served.
- The arbiter has no state other than the counter, the read tag, `hst_rdata` and `hst_rvalid`.

## Timing
- Reset values:
  - `hst_ack` 0, `hst_rvalid` 0, `hst_rdata` 0.
  - `wr_dev_ready` 1, `rd_dev_ready` 1.
  - `mem_we` 0, `mem_re` 0.
  - Counter 0, read tag 0.
- Idle-port host access: `hst_ack` in the cycle `hst_req` rises (0-cycle grant).
- Host read latency: `hst_rvalid` 2 cycles after `hst_ack`.
- Back-to-back host accesses: a new request is allowed in the cycle after `hst_ack`. Throughput is 1 access per cycle.
- Worst-case host grant under continuous AXI traffic: STARVE_LIMIT + 2 cycles after `hst_req` rises.
- `hst_req` dropping without ack (protocol violation): the counter clears and nothing is issued.
- Reset mid-operation: a pending read tag is dropped, so there is no `hst_rvalid` after reset. Throttle is released immediately (asynchronous).
- `mem_*` outputs are combinational from the enables. There is no registered stage on the address/data path.

## Test plan
- Host read of address 0x0010 with both ports idle, memory preloaded 0xA5A5_0001:
  - `hst_ack` same cycle.
  - `hst_rvalid` 2 cycles later, `hst_rdata` = 0xA5A5_0001.
- AXI write to 0x0004 and host write to 0x0008 in the same cycle:
  - AXI is written first.
  - `hst_ack` on the first cycle `axi_wen` = 0.
  - Both values are read back correctly.
- Continuous `axi_ren` burst, STARVE_LIMIT = 8, host read pending:
  - `rd_dev_ready` falls after 8 blocked cycles.
  - `hst_ack` ≤ 2 cycles later.
  - `rd_dev_ready` returns to 1 the cycle after `hst_ack`.
- AXI write 0xDEAD_BEEF and host read of the same address in the same cycle:
  - The host gets the old value.
  - A following host read returns 0xDEAD_BEEF.
- Host write with `hst_wstb` = 4'b0010, data 0x0000_AB00, over 0x1111_1111:
  - Readback is 0x1111_AB11.
- `ARESETN` pulsed low in the cycle after a host read `hst_ack`:
  - No `hst_rvalid` follows.
  - All outputs are at reset values.
  - The counter restarts from 0.

Source files
------------

// File: rtl/regs_port_arbiter.sv
// Shares the simple dual-port register memory between the AXI converters and the host/DMA engine.
// AXI always wins a port; the host takes idle slots, and a starvation counter throttles AXI.
module regs_port_arbiter #(
  parameter int unsigned ADDR_BITS    = 16,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic                 ACLK,
  input  logic                 ARESETN,
  input  logic [ADDR_BITS-1:0] axi_waddr,
  input  logic                 axi_wen,
  input  logic [3:0]           axi_wstb,
  input  logic [31:0]          axi_wdata,
  input  logic [ADDR_BITS-1:0] axi_raddr,
  input  logic                 axi_ren,
  input  logic                 axi_regen,
  output logic [31:0]          axi_rdata,
  output logic                 wr_dev_ready,
  output logic                 rd_dev_ready,
  input  logic                 hst_req,
  input  logic                 hst_we,
  input  logic [ADDR_BITS-1:0] hst_addr,
  input  logic [31:0]          hst_wdata,
  input  logic [3:0]           hst_wstb,
  output logic                 hst_ack,
  output logic [31:0]          hst_rdata,
  output logic                 hst_rvalid,
  output logic [ADDR_BITS-1:0] mem_waddr,
  output logic                 mem_we,
  output logic [3:0]           mem_wstb,
  output logic [31:0]          mem_wdata,
  output logic [ADDR_BITS-1:0] mem_raddr,
  output logic                 mem_re,
  input  logic [31:0]          mem_rdata
);

  localparam logic [7:0] Limit = 8'(STARVE_LIMIT);

  logic       host_wr_req;
  logic       host_rd_req;
  logic       throttle;
  logic [7:0] starve_q, starve_d;
  logic       rd_tag_q, rd_tag_d;
  logic [31:0] hst_rdata_q;
  logic       hst_rvalid_q;

  // The converter registers read data itself on axi_regen.
  logic unused_regen;
  assign unused_regen = axi_regen;

  assign host_wr_req = hst_req & hst_we;
  assign host_rd_req = hst_req & ~hst_we;

  always_comb begin
    mem_we    = axi_wen | host_wr_req;
    mem_waddr = hst_addr;
    mem_wstb  = hst_wstb;
    mem_wdata = hst_wdata;
    if (axi_wen) begin
      mem_waddr = axi_waddr;
      mem_wstb  = axi_wstb;
      mem_wdata = axi_wdata;
    end
  end

  always_comb begin
    mem_re    = axi_ren | host_rd_req;
    mem_raddr = axi_ren ? axi_raddr : hst_addr;
  end

  assign hst_ack   = (host_wr_req & ~axi_wen) | (host_rd_req & ~axi_ren);
  assign axi_rdata = mem_rdata;
  assign rd_tag_d  = host_rd_req & ~axi_ren;

  always_comb begin
    starve_d = 8'd0;
    if (hst_req && !hst_ack) begin
      starve_d = (starve_q == Limit) ? starve_q : starve_q + 8'd1;
    end
  end

  // Only the port the pending host access needs is throttled.
  assign throttle     = (starve_q == Limit) & hst_req;
  assign wr_dev_ready = ~(throttle & hst_we);
  assign rd_dev_ready = ~(throttle & ~hst_we);

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      starve_q     <= 8'd0;
      rd_tag_q     <= 1'b0;
      hst_rdata_q  <= 32'd0;
      hst_rvalid_q <= 1'b0;
    end else begin
      starve_q     <= starve_d;
      rd_tag_q     <= rd_tag_d;
      hst_rvalid_q <= rd_tag_q;
      if (rd_tag_q) begin
        hst_rdata_q <= mem_rdata;
      end
    end
  end

  assign hst_rdata  = hst_rdata_q;
  assign hst_rvalid = hst_rvalid_q;

endmodule

// File: tb/tb_regs_port_arbiter.sv
// Randomized scoreboard bench for regs_port_arbiter with a behavioural register memory.
module tb_regs_port_arbiter;
  localparam int unsigned AB    = 16;
  localparam int unsigned LIMIT = 8;

  logic          ACLK = 1'b0;
  logic          ARESETN = 1'b0;
  logic [AB-1:0] axi_waddr = '0, axi_raddr = '0, hst_addr = '0;
  logic          axi_wen = 1'b0, axi_ren = 1'b0, axi_regen = 1'b0;
  logic [3:0]    axi_wstb = '0, hst_wstb = '0;
  logic [31:0]   axi_wdata = '0, hst_wdata = '0;
  logic [31:0]   axi_rdata, hst_rdata, mem_wdata, mem_rdata;
  logic          wr_dev_ready, rd_dev_ready, hst_ack, hst_rvalid, mem_we, mem_re;
  logic          hst_req = 1'b0, hst_we = 1'b0;
  logic [AB-1:0] mem_waddr, mem_raddr;
  logic [3:0]    mem_wstb;

  regs_port_arbiter #(.ADDR_BITS(AB), .STARVE_LIMIT(LIMIT)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .axi_waddr(axi_waddr), .axi_wen(axi_wen), .axi_wstb(axi_wstb), .axi_wdata(axi_wdata),
    .axi_raddr(axi_raddr), .axi_ren(axi_ren), .axi_regen(axi_regen), .axi_rdata(axi_rdata),
    .wr_dev_ready(wr_dev_ready), .rd_dev_ready(rd_dev_ready),
    .hst_req(hst_req), .hst_we(hst_we), .hst_addr(hst_addr), .hst_wdata(hst_wdata),
    .hst_wstb(hst_wstb), .hst_ack(hst_ack), .hst_rdata(hst_rdata), .hst_rvalid(hst_rvalid),
    .mem_waddr(mem_waddr), .mem_we(mem_we), .mem_wstb(mem_wstb), .mem_wdata(mem_wdata),
    .mem_raddr(mem_raddr), .mem_re(mem_re), .mem_rdata(mem_rdata)
  );

  always #5 ACLK = ~ACLK;

  // Register memory: latency 1, read-first on same-address collision.
  logic [31:0] mem [256];
  always @(posedge ACLK) begin
    if (mem_re) mem_rdata <= mem[mem_raddr[7:0]];
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_wstb[b]) mem[mem_waddr[7:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
  end

  int cyc = 0;
  always @(posedge ACLK) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t hq[$];
  exp_t aq[$];
  logic [31:0] ref_mem [32];
  int n_checks = 0;
  int n_errors = 0;

  // Host-side request state and the reference view of throttling.
  logic        h_req = 1'b0, h_we = 1'b0;
  logic [AB-1:0] h_addr = '0;
  logic [31:0] h_wdata = '0;
  logic [3:0]  h_wstb = '0;
  int          blocked = 0;
  logic        prev_wrdy = 1'b1, prev_rrdy = 1'b1, last_ren = 1'b0, acked = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic ref_write(input logic [AB-1:0] a, input logic [3:0] s, input logic [31:0] d);
    for (int b = 0; b < 4; b++) begin
      if (s[b]) ref_mem[a[4:0]][8*b +: 8] = d[8*b +: 8];
    end
  endtask

  task automatic step(input logic awen_in, input logic [AB-1:0] wa, input logic [3:0] ws,
                      input logic [31:0] wd, input logic aren_in, input logic [AB-1:0] ra);
    logic awen, aren, thr, e_ack, e_wrdy, e_rrdy;
    exp_t e;
    @(negedge ACLK);
    awen = awen_in & prev_wrdy;
    aren = aren_in & prev_rrdy;
    axi_wen = awen; axi_waddr = wa; axi_wstb = ws; axi_wdata = wd;
    axi_ren = aren; axi_raddr = ra;
    axi_regen = last_ren; last_ren = aren;
    hst_req = h_req; hst_we = h_we; hst_addr = h_addr; hst_wdata = h_wdata; hst_wstb = h_wstb;
    thr    = h_req && (blocked >= LIMIT);
    e_wrdy = !(thr && h_we);
    e_rrdy = !(thr && !h_we);
    e_ack  = h_req && (h_we ? !awen : !aren);
    #1;
    check("hst_ack", {31'd0, hst_ack}, {31'd0, e_ack});
    check("wr_dev_ready", {31'd0, wr_dev_ready}, {31'd0, e_wrdy});
    check("rd_dev_ready", {31'd0, rd_dev_ready}, {31'd0, e_rrdy});
    check("mem_we", {31'd0, mem_we}, {31'd0, awen | (h_req & h_we)});
    check("mem_re", {31'd0, mem_re}, {31'd0, aren | (h_req & ~h_we)});
    if (aren) begin
      e.data = ref_mem[ra[4:0]]; e.due = cyc + 1; aq.push_back(e);
    end
    if (e_ack && !h_we) begin
      e.data = ref_mem[h_addr[4:0]]; e.due = cyc + 2; hq.push_back(e);
    end
    if (awen) ref_write(wa, ws, wd);
    else if (e_ack && h_we) ref_write(h_addr, h_wstb, h_wdata);
    blocked = (h_req && !e_ack) ? blocked + 1 : 0;
    acked = e_ack;
    if (e_ack) h_req = 1'b0;
    prev_wrdy = e_wrdy;
    prev_rrdy = e_rrdy;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, '0, 1'b0, '0);
  endtask

  task automatic host_access(input logic we, input logic [AB-1:0] a, input logic [31:0] d,
                             input logic [3:0] s);
    int k;
    h_req = 1'b1; h_we = we; h_addr = a; h_wdata = d; h_wstb = s;
    k = 0;
    do begin
      step(1'b0, '0, '0, '0, 1'b0, '0);
      k++;
    end while (!acked && k < 20);
    if (!acked) begin
      n_checks++; n_errors++;
      $display("FAIL host_access_timeout: no ack after %0d cycles", k);
      h_req = 1'b0;
    end
  endtask

  task automatic check_reset_values();
    check("rst_hst_ack", {31'd0, hst_ack}, 32'd0);
    check("rst_hst_rvalid", {31'd0, hst_rvalid}, 32'd0);
    check("rst_hst_rdata", hst_rdata, 32'd0);
    check("rst_wr_dev_ready", {31'd0, wr_dev_ready}, 32'd1);
    check("rst_rd_dev_ready", {31'd0, rd_dev_ready}, 32'd1);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("rst_mem_re", {31'd0, mem_re}, 32'd0);
  endtask

  // Monitor: compares whenever the DUT presents read data.
  always @(posedge ACLK) begin
    exp_t e;
    #3;
    if (ARESETN) begin
      if (hst_rvalid) begin
        if (hq.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL unexpected_rvalid: rdata %h with nothing outstanding", hst_rdata);
        end else begin
          e = hq.pop_front();
          check("hst_rdata", hst_rdata, e.data);
          check("rvalid_cycle", cyc, e.due);
        end
      end else if (hq.size() > 0 && hq[0].due < cyc) begin
        e = hq.pop_front();
        n_checks++; n_errors++;
        $display("FAIL missing_rvalid: due cycle %0d, now %0d", e.due, cyc);
      end
      if (aq.size() > 0 && aq[0].due == cyc) begin
        e = aq.pop_front();
        check("axi_rdata", axi_rdata, e.data);
      end
    end
  end

  initial begin
    int k;
    logic saw_throttle;
    repeat (3) @(negedge ACLK);
    #1 check_reset_values();
    @(negedge ACLK) ARESETN = 1'b1;

    // Known contents for every address the bench uses.
    for (int i = 0; i < 32; i++) step(1'b1, AB'(i), 4'hF, $urandom, 1'b0, '0);

    // Idle-port host read.
    host_access(1'b1, 16'h0010, 32'hA5A5_0001, 4'hF);
    host_access(1'b0, 16'h0010, '0, 4'h0);
    idle(3);

    // AXI write and host write collide: AXI first, host acked next cycle.
    h_req = 1'b1; h_we = 1'b1; h_addr = 16'h0008; h_wdata = 32'h0808_0808; h_wstb = 4'hF;
    step(1'b1, 16'h0004, 4'hF, 32'h0404_0404, 1'b0, '0);
    step(1'b0, '0, '0, '0, 1'b0, '0);
    host_access(1'b0, 16'h0004, '0, 4'h0);
    host_access(1'b0, 16'h0008, '0, 4'h0);

    // Same-cycle AXI write and host read of one address: read-first.
    h_req = 1'b1; h_we = 1'b0; h_addr = 16'h000C;
    step(1'b1, 16'h000C, 4'hF, 32'hDEAD_BEEF, 1'b0, '0);
    host_access(1'b0, 16'h000C, '0, 4'h0);

    // Byte-strobed host write.
    host_access(1'b1, 16'h0014, 32'h1111_1111, 4'hF);
    host_access(1'b1, 16'h0014, 32'h0000_AB00, 4'b0010);
    host_access(1'b0, 16'h0014, '0, 4'h0);
    idle(3);

    // Reset in the cycle after a host read ack drops the pending read.
    host_access(1'b0, 16'h0010, '0, 4'h0);
    @(negedge ACLK);
    axi_wen = 1'b0; axi_ren = 1'b0; axi_regen = 1'b0; hst_req = 1'b0;
    ARESETN = 1'b0;
    hq.delete();
    blocked = 0; prev_wrdy = 1'b1; prev_rrdy = 1'b1; last_ren = 1'b0;
    #1 check_reset_values();
    #1 ARESETN = 1'b1;
    idle(4);

    // Continuous AXI read burst starves a host read until throttling kicks in.
    h_req = 1'b1; h_we = 1'b0; h_addr = 16'h0008;
    k = 0; saw_throttle = 1'b0;
    do begin
      step(1'b0, '0, '0, '0, 1'b1, AB'($urandom_range(0, 31)));
      if (!rd_dev_ready) saw_throttle = 1'b1;
      k++;
    end while (!acked && k < 40);
    check("burst_throttle_seen", {31'd0, saw_throttle}, 32'd1);
    check("burst_grant_bound", {31'd0, (acked && k <= LIMIT + 2)}, 32'd1);
    for (int i = 0; i < 4; i++) step(1'b0, '0, '0, '0, 1'b1, AB'($urandom_range(0, 31)));

    // Host request withdrawn without ack: nothing issued, counter cleared.
    h_req = 1'b1; h_we = 1'b1; h_addr = 16'h0003; h_wdata = 32'h3333_3333; h_wstb = 4'hF;
    for (int i = 0; i < 3; i++) step(1'b1, AB'($urandom_range(0, 31)), 4'hF, $urandom, 1'b0, '0);
    h_req = 1'b0;
    step(1'b1, 16'h0005, 4'hF, $urandom, 1'b0, '0);
    idle(2);

    // Randomized mixed traffic.
    for (int i = 0; i < 400; i++) begin
      if (!h_req && ($urandom_range(0, 9) < 6)) begin
        h_req = 1'b1; h_we = 1'($urandom); h_addr = AB'($urandom_range(0, 31));
        h_wdata = $urandom; h_wstb = 4'($urandom);
      end
      step(1'($urandom_range(0, 9) < 5), AB'($urandom_range(0, 31)), 4'($urandom), $urandom,
           1'($urandom_range(0, 9) < 5), AB'($urandom_range(0, 31)));
    end
    h_req = 1'b0;
    idle(5);
    check("host_queue_drained", hq.size(), 32'd0);
    check("axi_queue_drained", aq.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
